// File: rtl/fft2d_frame_loader_if.sv
// Sample stream into the frame loader: valid/ready handshake carrying one
// complex sample per beat plus an end-of-frame marker.
interface fft2d_frame_loader_if #(
  parameter int unsigned DATA_W = 64
);
  logic              s_tvalid;
  logic              s_tready;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tlast;

  modport master (output s_tvalid, output s_tdata, output s_tlast, input s_tready);
  modport slave  (input s_tvalid, input s_tdata, input s_tlast, output s_tready);
endinterface

// File: rtl/fft2d_frame_loader.sv
// Collects a row-major sample stream into an N_POINT x N_POINT frame and holds
// it for the 2D FFT until the FFT signals consumption with fft_tlast.
module fft2d_frame_loader #(
  parameter int unsigned N_POINT = 8,
  parameter int unsigned DATA_W  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft2d_frame_loader_if.slave   s_if,
  output logic [DATA_W-1:0]     frame_out [N_POINT][N_POINT],
  output logic                  frame_valid,
  input  logic                  fft_tlast,
  output logic                  err_len,
  output logic [7:0]            frame_count
);

  localparam int unsigned N_SAMP = N_POINT * N_POINT;
  localparam int unsigned IDX_W  = (N_SAMP > 1) ? $clog2(N_SAMP) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMP - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              s_tready_q, s_tready_d;
  logic              frame_valid_q, frame_valid_d;
  logic              err_len_q, err_len_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic [DATA_W-1:0] frame_q [N_POINT][N_POINT];
  logic [DATA_W-1:0] frame_d [N_POINT][N_POINT];
  logic              accept_c;

  assign accept_c = s_if.s_tvalid & s_tready_q;

  // Next-state, sample write and status update.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    s_tready_d    = s_tready_q;
    frame_valid_d = frame_valid_q;
    err_len_d     = err_len_q;
    frame_count_d = frame_count_q;
    frame_d       = frame_q;

    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (accept_c) begin
          for (int unsigned r = 0; r < N_POINT; r++) begin
            for (int unsigned c = 0; c < N_POINT; c++) begin
              if (idx_q == IDX_W'(r * N_POINT + c)) frame_d[r][c] = s_if.s_tdata;
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d       = ST_HOLD;
            idx_d         = '0;
            s_tready_d    = 1'b0;
            frame_valid_d = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
            if (!s_if.s_tlast) err_len_d = 1'b1;
          end else if (s_if.s_tlast) begin
            // Short frame: keep the written beats but never present them as valid.
            state_d   = ST_IDLE;
            idx_d     = '0;
            err_len_d = 1'b1;
          end else begin
            state_d = ST_FILL;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (fft_tlast) begin
          state_d       = ST_IDLE;
          s_tready_d    = 1'b1;
          frame_valid_d = 1'b0;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        idx_d         = '0;
        s_tready_d    = 1'b1;
        frame_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      s_tready_q    <= 1'b1;
      frame_valid_q <= 1'b0;
      err_len_q     <= 1'b0;
      frame_count_q <= 8'd0;
      for (int unsigned r = 0; r < N_POINT; r++) begin
        for (int unsigned c = 0; c < N_POINT; c++) begin
          frame_q[r][c] <= '0;
        end
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      s_tready_q    <= s_tready_d;
      frame_valid_q <= frame_valid_d;
      err_len_q     <= err_len_d;
      frame_count_q <= frame_count_d;
      frame_q       <= frame_d;
    end
  end

  assign s_if.s_tready = s_tready_q;
  assign frame_valid   = frame_valid_q;
  assign err_len       = err_len_q;
  assign frame_count   = frame_count_q;
  assign frame_out     = frame_q;

endmodule

// File: tb/tb_fft2d_frame_loader.sv
// Directed bench for fft2d_frame_loader: accepted beats go to a scoreboard and
// are checked against frame_out when the frame completes or is discarded.
module tb_fft2d_frame_loader;

  localparam int N    = 8;
  localparam int NS   = N * N;
  localparam int LAST = NS - 1;

  logic        clk;
  logic        rst_n;
  logic        fft_tlast;
  logic [63:0] frame_out [N][N];
  logic        frame_valid;
  logic        err_len;
  logic [7:0]  frame_count;

  fft2d_frame_loader_if #(.DATA_W(64)) s_if ();

  fft2d_frame_loader #(.N_POINT(N), .DATA_W(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_if        (s_if),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .fft_tlast   (fft_tlast),
    .err_len     (err_len),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [63:0] data;
  } beat_t;

  beat_t       sb [$];
  logic [63:0] m_frame [NS];
  bit          m_hold;
  int          m_idx;
  bit          m_err;
  logic [7:0]  m_cnt;
  int          vectors;
  int          miscompares;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    beat_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("frame_out[%0d][%0d]", e.idx / N, e.idx % N),
          frame_out[e.idx / N][e.idx % N], e.data);
    end
  endtask

  task automatic chk_status();
    chk("s_tready", {63'd0, s_if.s_tready}, {63'd0, !m_hold});
    chk("frame_valid", {63'd0, frame_valid}, {63'd0, m_hold});
    chk("err_len", {63'd0, err_len}, {63'd0, m_err});
    chk("frame_count", {56'd0, frame_count}, {56'd0, m_cnt});
  endtask

  task automatic chk_frame(input string tag);
    for (int i = 0; i < NS; i++) chk($sformatf("%s[%0d]", tag, i), frame_out[i / N][i % N], m_frame[i]);
  endtask

  // One clock: predict the edge from the driven inputs, then check.
  task automatic cycle();
    bit          tv, tl, ft;
    logic [63:0] d;
    tv = s_if.s_tvalid;
    tl = s_if.s_tlast;
    d  = s_if.s_tdata;
    ft = fft_tlast;
    @(posedge clk);
    #1;
    if (m_hold) begin
      if (ft) m_hold = 1'b0;
    end else if (tv) begin
      m_frame[m_idx] = d;
      sb.push_back('{idx: m_idx, data: d});
      if (m_idx == LAST) begin
        m_hold = 1'b1;
        m_idx  = 0;
        m_cnt  = m_cnt + 8'd1;
        if (!tl) m_err = 1'b1;
        drain();
      end else if (tl) begin
        m_err = 1'b1;
        m_idx = 0;
        drain();
      end else begin
        m_idx++;
      end
    end
    chk_status();
  endtask

  task automatic feed(input int base, input int tlast_at, input bit gaps, input int nbeats);
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    while (sent < nbeats && guard < 1000) begin
      s_if.s_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_if.s_tdata  = {32'(m_idx + base), 32'(base)};
      s_if.s_tlast  = (m_idx == tlast_at);
      if (s_if.s_tvalid && !m_hold) sent++;
      cycle();
      guard++;
    end
    chk("feed_budget", 64'(sent), 64'(nbeats));
    s_if.s_tvalid = 1'b0;
    s_if.s_tlast  = 1'b0;
  endtask

  task automatic hold_check(input int ncyc);
    s_if.s_tvalid = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      s_if.s_tdata = {$urandom, $urandom};
      s_if.s_tlast = 1'($urandom_range(0, 1));
      cycle();
    end
    s_if.s_tvalid = 1'b0;
    s_if.s_tlast  = 1'b0;
    chk_frame("hold_frame");
  endtask

  task automatic release_frame();
    fft_tlast = 1'b1;
    cycle();
    fft_tlast = 1'b0;
  endtask

  task automatic model_reset();
    m_hold = 1'b0;
    m_idx  = 0;
    m_err  = 1'b0;
    m_cnt  = 8'd0;
    for (int i = 0; i < NS; i++) m_frame[i] = 64'd0;
    sb.delete();
  endtask

  // Assert reset between edges, check without any clock, release after negedge.
  task automatic async_reset();
    s_if.s_tvalid = 1'b0;
    s_if.s_tlast  = 1'b0;
    fft_tlast     = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_status();
    chk_frame("reset_frame");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_status();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b1;
    fft_tlast     = 1'b0;
    s_if.s_tvalid = 1'b0;
    s_if.s_tdata  = 64'd0;
    s_if.s_tlast  = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk_status();
    chk_frame("por_frame");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contiguous frame with data {idx, 0}
    feed(0, LAST, 1'b0, NS);
    chk("first_count", {56'd0, frame_count}, 64'd1);
    chk("first_r7c5", frame_out[7][5], {32'd61, 32'd0});
    hold_check(10);
    release_frame();

    // Backpressured frame with random gaps
    feed(100, LAST, 1'b1, NS);
    hold_check(10);
    release_frame();

    // Early tlast on beat 10, then a clean frame
    feed(200, 10, 1'b0, 11);
    chk("early_err", {63'd0, err_len}, 64'd1);
    feed(300, LAST, 1'b0, NS);
    hold_check(2);
    release_frame();

    // Missing tlast on the final beat
    feed(400, -1, 1'b0, NS);
    release_frame();

    // Reset mid-fill and mid-hold
    feed(500, LAST, 1'b0, 31);
    async_reset();
    feed(600, LAST, 1'b0, NS);
    async_reset();
    feed(700, LAST, 1'b0, NS);
    release_frame();

    // fft_tlast during fill is ignored
    fft_tlast = 1'b1;
    feed(800, LAST, 1'b0, 40);
    fft_tlast = 1'b0;
    feed(800, LAST, 1'b0, NS - 40);
    hold_check(2);
    release_frame();

    // 256 frames wrap the counter back to zero
    async_reset();
    for (int f = 0; f < 256; f++) begin
      feed(f * 3 + 1, LAST, 1'b0, NS);
      release_frame();
    end
    chk("wrap_count", {56'd0, frame_count}, 64'd0);
    chk("wrap_err", {63'd0, err_len}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft2d_frame_loader.md
FFT2D_FRAME_LOADER -- requirements
Module: fft2d_frame_loader

Interface
REQ-001 Parameter N_POINT, default 8, SHALL set the frame dimension; one frame is N_POINT x N_POINT samples (64 at default).
REQ-002 Parameter DATA_W, default 64, SHALL set the sample width; each sample is {real[DATA_W-1:DATA_W/2], imag[DATA_W/2-1:0]} and passes through unmodified.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert and active-low; synchronous release.
REQ-005 s_tvalid  input  1  upstream sample valid.
REQ-006 s_tready  output  1  loader can accept a sample this cycle.
REQ-007 s_tdata  input  DATA_W  sample, row-major order (row 0 col 0 first).
REQ-008 s_tlast  input  1  upstream marks last sample of a frame.
REQ-009 frame_out  output  DATA_W x [N_POINT][N_POINT] unpacked array  assembled frame, indexed [row][col], driving the FFT_2D inp_2d port.
REQ-010 frame_valid  output  1  frame_out is complete and stable; drives FFT_2D valid.
REQ-011 fft_tlast  input  1  FFT_2D data_tlast; signals the frame has been consumed.
REQ-012 err_len  output  1  sticky framing-error flag.
REQ-013 frame_count  output  8  number of frames delivered, modulo 256.

Function
REQ-014 Handshake SHALL be beat-accepted iff s_tvalid and s_tready are both 1 at a rising edge.
REQ-015 State machine SHALL have states IDLE, FILL and HOLD.
REQ-016 IDLE: s_tready=1, frame_valid=0. The first accepted beat SHALL write index 0 and move the block to FILL.
REQ-017 FILL: s_tready=1. Each accepted beat SHALL write frame_out[idx/N_POINT][idx%N_POINT] and then increment idx, a 6-bit counter at default.
REQ-018 When beat idx=N_POINT*N_POINT-1 is accepted, the block SHALL do all of the following on that same edge: go to HOLD, set frame_valid=1, set s_tready=0, reset idx to 0, and increment frame_count.
REQ-019 HOLD: s_tready=0, frame_valid=1, and frame_out is held constant. fft_tlast=1 at an edge SHALL return the block to IDLE, with frame_valid=0 and s_tready=1 after that edge.
REQ-020 fft_tlast in IDLE or FILL SHALL be ignored.
REQ-021 An accepted beat with s_tlast=1 and idx<N_POINT*N_POINT-1 (early tlast) SHALL:
  - set err_len;
  - write that beat;
  - discard the partial frame: reset idx to 0 and go to IDLE with no frame_valid pulse and no frame_count increment.
REQ-022 An accepted final beat (idx=N_POINT*N_POINT-1) with s_tlast=0 SHALL set err_len, and the frame SHALL still be delivered per REQ-018.
REQ-023 err_len SHALL stay 1 until reset.
REQ-024 frame_count SHALL wrap from 255 to 0.
REQ-025 Discarded frames SHALL leave stale entries in frame_out; frame_valid=0 marks them as invalid.
REQ-026 s_tready SHALL be a registered output (no combinational path from any input).
REQ-027 frame_valid SHALL be a registered output (no combinational path from any input).
REQ-028 Throughput SHALL be 1 beat/cycle in IDLE and FILL.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately set the following, regardless of clk:
  - state IDLE, idx 0;
  - s_tready=1, frame_valid=0;
  - err_len=0, frame_count=0;
  - every frame_out entry 0.
REQ-030 Reset mid-FILL or mid-HOLD SHALL abandon the frame; the first accepted beat after release is index 0.

Verification
REQ-031 Contiguous frame: 64 beats, s_tdata = {32'h(idx), 32'h0}, s_tlast on beat 63, s_tvalid held high -> s_tready drops and frame_valid rises on the edge accepting beat 63; frame_out[r][c] = {r*8+c, 0}; frame_count=1; err_len=0.
REQ-032 Backpressure/idle gaps: same frame with s_tvalid toggling randomly, plus s_tvalid=1 held 10 cycles in HOLD -> identical frame_out; no beats accepted in HOLD; fft_tlast pulse -> s_tready=1 next cycle; next frame starts at [0][0].
REQ-033 Early tlast: s_tlast on beat 10 -> err_len=1, no frame_valid, frame_count unchanged; a following clean 64-beat frame is delivered correctly with err_len still 1.
REQ-034 Missing tlast: 64 beats with no s_tlast -> frame_valid=1, err_len=1, frame_count increments.
REQ-035 Reset mid-operation: rst_n=0 after beat 30 and again during HOLD -> all outputs reach reset values without a clock edge; a following frame is loaded from index 0.
REQ-036 Wrap and spurious inputs: 256 back-to-back frames each released by fft_tlast -> frame_count returns to 0; fft_tlast pulsed during FILL -> no state change.
